// File: rtl/sync_ctrl_pkg.sv
// Shared types and defaults for the time-sync control engine.
package sync_ctrl_pkg;

    localparam int unsigned DEF_TS_WIDTH  = 48;
    localparam int unsigned DEF_BYTE_W    = 8;
    localparam int unsigned DEF_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_TRAN = 2'd1
    } tx_state_e;

    function automatic int unsigned ts_bytes(input int unsigned ts_w, input int unsigned byte_w);
        return ts_w / byte_w;
    endfunction

endpackage

// File: rtl/ts_byte_serializer.sv
// TX side: serialises a latched timestamp MSB-first and counts requests dropped while busy.
module ts_byte_serializer
    import sync_ctrl_pkg::*;
#(
    parameter int unsigned TS_WIDTH  = DEF_TS_WIDTH,
    parameter int unsigned BYTE_W    = DEF_BYTE_W,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [TS_WIDTH-1:0]  iv_clock_ts,
    input  logic                 i_clock_ts_wr,
    output logic [BYTE_W-1:0]    ov_sync_data,
    output logic                 o_sync_data_wr,
    output logic                 o_tx_busy,
    output logic [CNT_WIDTH-1:0] ov_tx_drop_cnt,
    output logic [1:0]           ov_tx_state
);

    localparam int unsigned TS_BYTES = ts_bytes(TS_WIDTH, BYTE_W);
    localparam int unsigned BC_W     = $clog2(TS_BYTES + 1);

    tx_state_e              state_q, state_d;
    logic [BC_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [TS_WIDTH-1:0]    shift_q, shift_d;
    logic [BYTE_W-1:0]      data_q, data_d;
    logic                   wr_q, wr_d;
    logic                   busy_q, busy_d;
    logic [CNT_WIDTH-1:0]   drop_q, drop_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        data_d     = '0;
        wr_d       = 1'b0;
        drop_d     = drop_q;
        case (state_q)
            TX_IDLE: begin
                if (i_clock_ts_wr) begin
                    // Remaining bytes are kept left-aligned so the next byte is always the top slice.
                    shift_d    = iv_clock_ts << BYTE_W;
                    data_d     = iv_clock_ts[TS_WIDTH-1 -: BYTE_W];
                    wr_d       = 1'b1;
                    byte_cnt_d = BC_W'(1);
                    state_d    = TX_TRAN;
                end
            end
            TX_TRAN: begin
                if (i_clock_ts_wr && drop_q != '1)
                    drop_d = drop_q + CNT_WIDTH'(1);
                if (byte_cnt_q < BC_W'(TS_BYTES)) begin
                    data_d     = shift_q[TS_WIDTH-1 -: BYTE_W];
                    wr_d       = 1'b1;
                    shift_d    = shift_q << BYTE_W;
                    byte_cnt_d = byte_cnt_q + BC_W'(1);
                end else begin
                    byte_cnt_d = '0;
                    state_d    = TX_IDLE;
                end
            end
            default: begin
                byte_cnt_d = '0;
                state_d    = TX_IDLE;
            end
        endcase
        // Busy also spans the idle gap cycle that closes each frame.
        busy_d = (state_d != TX_IDLE) || (state_q != TX_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= TX_IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
        end
    end

    assign ov_sync_data   = data_q;
    assign o_sync_data_wr = wr_q;
    assign o_tx_busy      = busy_q;
    assign ov_tx_drop_cnt = drop_q;
    assign ov_tx_state    = state_q;

endmodule

// File: rtl/sync_ctrl_engine.sv
// Time-sync engine: TX timestamp serialiser plus RX peer-timestamp assembly and offset compare.
module sync_ctrl_engine
    import sync_ctrl_pkg::*;
#(
    parameter int unsigned TS_WIDTH    = DEF_TS_WIDTH,
    parameter int unsigned BYTE_W      = DEF_BYTE_W,
    parameter int unsigned STICKY_MODE = 0,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [BYTE_W-1:0]    iv_app_data,
    input  logic                 i_app_data_wr,
    input  logic [TS_WIDTH-1:0]  iv_clock_ts,
    input  logic                 i_clock_ts_wr,
    input  logic [TS_WIDTH-1:0]  iv_offset_th,
    input  logic                 i_sim_ctrl_clr,
    output logic [BYTE_W-1:0]    ov_sync_data,
    output logic                 o_sync_data_wr,
    output logic                 o_tx_busy,
    output logic                 o_sim_ctrl,
    output logic [TS_WIDTH:0]    ov_offset,
    output logic                 o_cmp_valid,
    output logic [CNT_WIDTH-1:0] ov_tx_drop_cnt,
    output logic [CNT_WIDTH-1:0] ov_rx_err_cnt,
    output logic [1:0]           ov_tx_state
);

    localparam int unsigned TS_BYTES = ts_bytes(TS_WIDTH, BYTE_W);
    // One spare code above TS_BYTES so over-long bursts saturate without aliasing to a legal length.
    localparam int unsigned RXC_W    = $clog2(TS_BYTES + 2);

    logic [TS_WIDTH-1:0]  rx_ts_q, rx_ts_d;
    logic [RXC_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [TS_WIDTH:0]    offset_q, offset_d;
    logic                 sim_ctrl_q, sim_ctrl_d;
    logic                 cmp_valid_q, cmp_valid_d;
    logic [CNT_WIDTH-1:0] err_q, err_d;
    logic [TS_WIDTH-1:0]  diff;
    logic [TS_WIDTH:0]    offset_new, mag;
    logic                 exceed;

    always_comb begin
        diff       = iv_clock_ts - rx_ts_q;
        offset_new = {diff[TS_WIDTH-1], diff};
        mag        = offset_new[TS_WIDTH] ? (~offset_new + (TS_WIDTH+1)'(1)) : offset_new;
        exceed     = mag > {1'b0, iv_offset_th};

        rx_ts_d     = rx_ts_q;
        rx_cnt_d    = rx_cnt_q;
        offset_d    = offset_q;
        sim_ctrl_d  = sim_ctrl_q;
        cmp_valid_d = 1'b0;
        err_d       = err_q;

        if (i_app_data_wr) begin
            rx_ts_d = (rx_ts_q << BYTE_W) | TS_WIDTH'(iv_app_data);
            if (rx_cnt_q != '1)
                rx_cnt_d = rx_cnt_q + RXC_W'(1);
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = '0;
            if (rx_cnt_q == RXC_W'(TS_BYTES)) begin
                offset_d    = offset_new;
                cmp_valid_d = 1'b1;
                if (STICKY_MODE == 0)
                    sim_ctrl_d = exceed;
            end else if (err_q != '1) begin
                err_d = err_q + CNT_WIDTH'(1);
            end
        end

        if (STICKY_MODE != 0) begin
            if (cmp_valid_d && exceed)
                sim_ctrl_d = 1'b1;
            else if (i_sim_ctrl_clr)
                sim_ctrl_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_ts_q     <= '0;
            rx_cnt_q    <= '0;
            offset_q    <= '0;
            sim_ctrl_q  <= 1'b0;
            cmp_valid_q <= 1'b0;
            err_q       <= '0;
        end else begin
            rx_ts_q     <= rx_ts_d;
            rx_cnt_q    <= rx_cnt_d;
            offset_q    <= offset_d;
            sim_ctrl_q  <= sim_ctrl_d;
            cmp_valid_q <= cmp_valid_d;
            err_q       <= err_d;
        end
    end

    assign o_sim_ctrl    = sim_ctrl_q;
    assign ov_offset     = offset_q;
    assign o_cmp_valid   = cmp_valid_q;
    assign ov_rx_err_cnt = err_q;

    ts_byte_serializer #(
        .TS_WIDTH  (TS_WIDTH),
        .BYTE_W    (BYTE_W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tx (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .iv_clock_ts    (iv_clock_ts),
        .i_clock_ts_wr  (i_clock_ts_wr),
        .ov_sync_data   (ov_sync_data),
        .o_sync_data_wr (o_sync_data_wr),
        .o_tx_busy      (o_tx_busy),
        .ov_tx_drop_cnt (ov_tx_drop_cnt),
        .ov_tx_state    (ov_tx_state)
    );

endmodule
